// File: rtl/seg7_readback_decoder.sv
// seg7_readback_decoder
// Recovers a 0..19 binary value from a pair of active-low seven-segment
// digit patterns (tens, ones). Two register stages with valid/ready
// handshakes on both sides. Illegal patterns are flagged and counted.
module seg7_readback_decoder #(
  parameter int ERR_W = 8
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_tens,
  input  logic [6:0]       in_ones,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_value,
  output logic             out_err,
  output logic             out_range,
  input  logic             clear_err,
  output logic [ERR_W-1:0] err_count
);

  logic       s1_valid;
  logic [6:0] s1_tens;
  logic [6:0] s1_ones;

  logic       s2_free;
  logic       in_fire;
  logic       s1_adv;
  logic       out_fire;

  logic       tens_ok;
  logic       tens_d;
  logic       ones_ok;
  logic [3:0] ones_d;
  logic [4:0] sum;
  logic       dec_err;
  logic [4:0] dec_value;
  logic       dec_range;

  // Handshake and stage-advance conditions
  always_comb begin
    s2_free  = !out_valid || out_ready;
    in_ready = !s1_valid || s2_free;
    in_fire  = in_valid && in_ready;
    s1_adv   = s1_valid && s2_free;
    out_fire = out_valid && out_ready;
  end

  // Stage 1: capture raw patterns on an input transfer
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      s1_tens  <= '0;
      s1_ones  <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_tens  <= in_tens;
      s1_ones  <= in_ones;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Pattern decode between stage 1 and stage 2
  always_comb begin
    tens_ok = 1'b1;
    tens_d  = 1'b0;
    case (s1_tens)
      7'h7F:   tens_d  = 1'b0;
      7'h79:   tens_d  = 1'b1;
      default: tens_ok = 1'b0;
    endcase

    ones_ok = 1'b1;
    ones_d  = '0;
    case (s1_ones)
      7'h40:   ones_d  = 4'd0;
      7'h79:   ones_d  = 4'd1;
      7'h24:   ones_d  = 4'd2;
      7'h30:   ones_d  = 4'd3;
      7'h19:   ones_d  = 4'd4;
      7'h12:   ones_d  = 4'd5;
      7'h02:   ones_d  = 4'd6;
      7'h78:   ones_d  = 4'd7;
      7'h00:   ones_d  = 4'd8;
      7'h18:   ones_d  = 4'd9;
      default: ones_ok = 1'b0;
    endcase

    sum       = (tens_d ? 5'd10 : 5'd0) + {1'b0, ones_d};
    dec_err   = !(tens_ok && ones_ok);
    dec_value = dec_err ? '0 : sum;
    dec_range = !dec_err && (sum >= 5'd16);
  end

  // Stage 2: hold decoded result until the downstream stage takes it
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_value <= '0;
      out_err   <= 1'b0;
      out_range <= 1'b0;
    end else if (s1_adv) begin
      out_valid <= 1'b1;
      out_value <= dec_value;
      out_err   <= dec_err;
      out_range <= dec_range;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating count of errored results handed downstream; clear wins
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      err_count <= '0;
    end else if (clear_err) begin
      err_count <= '0;
    end else if (out_fire && out_err && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_readback_decoder.sv
// Directed and randomized checks for seg7_readback_decoder. A second
// instance with a 2-bit error counter shares the stimulus to exercise
// saturation.
module tb_seg7_readback_decoder;

  logic       CLOCK_50;
  logic       resetn;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_tens;
  logic [6:0] in_ones;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] out_value;
  logic       out_err;
  logic       out_range;
  logic       clear_err;
  logic [7:0] err_count;

  logic       sat_in_ready;
  logic       sat_out_valid;
  logic [4:0] sat_out_value;
  logic       sat_out_err;
  logic       sat_out_range;
  logic [1:0] sat_err_count;

  int checks = 0;
  int errors = 0;

  logic [6:0] ones_pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h18};

  seg7_readback_decoder #(.ERR_W(8)) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_tens(in_tens), .in_ones(in_ones),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_value(out_value), .out_err(out_err), .out_range(out_range),
    .clear_err(clear_err), .err_count(err_count)
  );

  seg7_readback_decoder #(.ERR_W(2)) dut_sat (
    .CLOCK_50(CLOCK_50), .resetn(resetn),
    .in_valid(in_valid), .in_ready(sat_in_ready),
    .in_tens(in_tens), .in_ones(in_ones),
    .out_valid(sat_out_valid), .out_ready(out_ready),
    .out_value(sat_out_value), .out_err(sat_out_err), .out_range(sat_out_range),
    .clear_err(clear_err), .err_count(sat_err_count)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; in_valid = 1'b0; in_tens = 7'h7F; in_ones = 7'h40;
    out_ready = 1'b0; clear_err = 1'b0;
    #3;
    checks++;
    if (out_valid !== 1'b0 || err_count !== 8'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_init: got valid=%b cnt=%0d rdy=%b expected 0 0 1", out_valid, err_count, in_ready);
    end
    tick();
    resetn = 1'b1;
    // fill both stages with errored pairs while stalled
    in_valid = 1'b1; in_tens = 7'h7F; in_ones = 7'h7F;
    tick();
    tick();
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_full: got rdy=%b valid=%b expected 0 1", in_ready, out_valid);
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    resetn = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || err_count !== 8'd0 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got valid=%b cnt=%0d err=%b expected 0 0 0", out_valid, err_count, out_err);
    end
    tick();
    resetn = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1", in_ready);
    end
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_discard: got valid=%b cnt=%0d expected 0 0", out_valid, err_count);
    end
  endtask

  task automatic test_sweep();
    logic [6:0] exp_o;
    out_ready = 1'b1;
    for (int k = 0; k < 22; k++) begin
      if (k < 20) begin
        in_valid = 1'b1;
        in_tens  = (k < 10) ? 7'h7F : 7'h79;
        in_ones  = ones_pat[k % 10];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (k < 20) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL sweep_ready k=%0d: got %b expected 1", k, in_ready);
        end
      end
      if (k >= 2) begin
        exp_o = {1'b1, 1'b0, ((k - 2) >= 16) ? 1'b1 : 1'b0, 4'b0} | 7'(0);
        exp_o = {1'b1, 1'b0, (k - 2) >= 16, 4'b0};
        checks++;
        if (out_valid !== 1'b1 || out_err !== 1'b0 || out_value !== 5'(k - 2) ||
            out_range !== ((k - 2) >= 16)) begin
          errors++;
          $display("FAIL sweep_out k=%0d: got v=%b val=%0d err=%b rng=%b expected 1 %0d 0 %b",
                   k, out_valid, out_value, out_err, out_range, k - 2, (k - 2) >= 16);
        end
      end else begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL sweep_lat k=%0d: got valid=%b expected 0", k, out_valid);
        end
      end
      tick();
    end
  endtask

  task automatic test_illegal();
    logic [6:0] bad_t [3] = '{7'h7F, 7'h40, 7'h79};
    logic [6:0] bad_o [3] = '{7'h7F, 7'h40, 7'h01};
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k < 3) begin
        in_valid = 1'b1; in_tens = bad_t[k]; in_ones = bad_o[k];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (k >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || out_err !== 1'b1 || out_value !== 5'd0 || out_range !== 1'b0) begin
          errors++;
          $display("FAIL illegal k=%0d: got v=%b err=%b val=%0d rng=%b expected 1 1 0 0",
                   k - 2, out_valid, out_err, out_value, out_range);
        end
      end
      tick();
    end
    checks++;
    if (err_count !== 8'd3 || sat_err_count !== 2'd3) begin
      errors++;
      $display("FAIL illegal_count: got %0d/%0d expected 3/3", err_count, sat_err_count);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_tens = 7'h7F; in_ones = 7'h12;   // 5
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_acc1: got rdy=%b expected 1", in_ready);
    end
    tick();
    in_tens = 7'h79; in_ones = 7'h24;                    // 12
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_acc2: got rdy=%b expected 1", in_ready);
    end
    tick();
    in_tens = 7'h7F; in_ones = 7'h78;                    // 7
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_value !== 5'd5 || out_err !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall c=%0d: got rdy=%b v=%b val=%0d expected 0 1 5", c, in_ready, out_valid, out_value);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_value !== 5'd5) begin
      errors++; $display("FAIL bp_release: got rdy=%b val=%0d expected 1 5", in_ready, out_value);
    end
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_value !== 5'd12 || out_range !== 1'b0) begin
      errors++; $display("FAIL bp_out12: got v=%b val=%0d expected 1 12", out_valid, out_value);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_value !== 5'd7) begin
      errors++; $display("FAIL bp_out7: got v=%b val=%0d expected 1 7", out_valid, out_value);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_drain: got v=%b expected 0", out_valid);
    end
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      in_valid = (k < 5);
      in_tens = 7'h40; in_ones = 7'h40;
      tick();
    end
    checks++;
    if (sat_err_count !== 2'd3 || err_count !== 8'd8) begin
      errors++;
      $display("FAIL sat_count: got %0d/%0d expected 3/8", sat_err_count, err_count);
    end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    clear_err = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_err !== 1'b1) begin
      errors++; $display("FAIL clr_setup: got v=%b err=%b expected 1 1", out_valid, out_err);
    end
    tick();
    clear_err = 1'b0;
    checks++;
    if (err_count !== 8'd0 || sat_err_count !== 2'd0) begin
      errors++;
      $display("FAIL clr_wins: got %0d/%0d expected 0/0", err_count, sat_err_count);
    end
  endtask

  task automatic test_random();
    logic [6:0] expq [$];
    logic [6:0] exp_r;
    logic [6:0] hold_r;
    logic       stalled;
    logic       have;
    int         sent;
    int         recv;
    int         cyc;
    int         ti;
    int         oi;
    int         val;
    logic       bad;
    sent = 0; recv = 0; cyc = 0; have = 1'b0; stalled = 1'b0; hold_r = '0;
    while (recv < 1000 && cyc < 20000) begin
      if (!have && sent < 1000) begin
        ti = $urandom_range(0, 2);
        oi = $urandom_range(0, 10);
        in_tens = (ti == 0) ? 7'h7F : (ti == 1) ? 7'h79 : 7'h40;
        in_ones = (oi == 10) ? 7'h7F : ones_pat[oi];
        bad = (ti == 2) || (oi == 10);
        val = bad ? 0 : ti * 10 + oi;
        have = 1'b1;
      end
      in_valid  = have && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || {out_err, out_range, out_value} !== hold_r) begin
          errors++;
          $display("FAIL rand_stable: got %h expected %h", {out_err, out_range, out_value}, hold_r);
        end
      end
      if (in_valid && in_ready) begin
        expq.push_back({bad, !bad && (val >= 16), 5'(val)});
        sent++;
        have = 1'b0;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL rand_extra: got val=%0d expected no output", out_value);
        end else begin
          exp_r = expq.pop_front();
          if ({out_err, out_range, out_value} !== exp_r) begin
            errors++;
            $display("FAIL rand_out n=%0d: got %h expected %h", recv, {out_err, out_range, out_value}, exp_r);
          end
        end
        recv++;
      end
      stalled = out_valid && !out_ready;
      hold_r = {out_err, out_range, out_value};
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (recv != 1000 || expq.size() != 0) begin
      errors++;
      $display("FAIL rand_total: got recv=%0d pending=%0d expected 1000 0", recv, expq.size());
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_illegal();
    test_backpressure();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_readback_decoder.md
# seg7_readback_decoder

Pipelined decoder that converts a pair of active-low seven-segment digit patterns (tens digit, ones digit) back into a 5-bit binary value. It is the inverse of the two-digit decimal display path and serves as a readback/self-check stage: the patterns driven to the two HEX digits are fed in, and the recovered value is compared against the original switch value. It uses valid/ready handshakes on both sides, flags illegal patterns, and keeps a saturating error count.

## Interface
Parameters:
- ERR_W, 8, width of the saturating error counter

Ports:
- CLOCK_50  input  1  system clock; all state updates on the rising edge
- resetn  input  1  asynchronous, active-low reset
- in_valid  input  1  the input pattern pair is valid
- in_ready  output  1  the block can accept a pair this cycle
- in_tens  input  7  tens digit pattern, active-low, bit order [6:0] = G F E D C B A
- in_ones  input  7  ones digit pattern, same encoding
- out_valid  output  1  a decoded result is available
- out_ready  input  1  the downstream stage accepts the result
- out_value  output  5  decoded binary value, 0..19
- out_err  output  1  at least one pattern is illegal; out_value is 0
- out_range  output  1  the value is legal but above 15 (16..19)
- clear_err  input  1  synchronous clear of err_count
- err_count  output  ERR_W  saturating count of errored results transferred

## Operation
- Legal tens patterns: 0x7F (blank) gives 0; 0x79 gives 1. Every other tens pattern is an error, including 0x40.
- Legal ones patterns:
  - 0x40 = 0, 0x79 = 1, 0x24 = 2, 0x30 = 3, 0x19 = 4
  - 0x12 = 5, 0x02 = 6, 0x78 = 7, 0x00 = 8, 0x18 = 9
  - Every other ones pattern, including 0x7F, is an error.
- Value calculation:
  - out_value = tens*10 + ones, computed at 5-bit width with no overflow possible.
  - out_range = legal result and value >= 16.
  - On error: out_value = 0 and out_range = 0.
- Pipeline, two register stages:
  - S1 captures the raw patterns whenever an input transfer occurs.
  - S2 holds the decoded result.
  - Pattern decode is combinational between S1 and S2.
- Input transfer occurs when in_valid && in_ready.
- Output transfer occurs when out_valid && out_ready.
- Ready and advance logic:
  - s2_free = !out_valid || out_ready
  - in_ready = !s1_valid || s2_free; it is purely combinational from registered state and out_ready.
  - S1 advances into S2 when s1_valid && s2_free.
  - Otherwise S2 holds its contents and out_* stay stable.
- Handshake rules:
  - While out_valid=1 and out_ready=0, out_value, out_err and out_range must not change.
  - in_tens and in_ones are sampled only on an input transfer.
- err_count:
  - Increments by 1 on each output transfer with out_err=1.
  - Saturates at 2^ERR_W-1.
  - clear_err=1 sets it to 0; clear wins over a simultaneous increment.

## Timing
- Reset values (resetn low, asynchronous): s1_valid=0, out_valid=0, out_value=0, out_err=0, out_range=0, err_count=0. in_ready=1 as soon as reset deasserts.
- Latency: an input accepted at edge N gives out_valid=1 after edge N+1, provided S2 is free.
- Throughput: one result per cycle while out_ready stays high.
- Backpressure:
  - With out_ready held low, the block accepts at most two pairs: one in S2, one in S1.
  - in_ready then drops to 0 in the cycle after the second accept.
  - The first cycle out_ready=1 releases S2, advances S1 into S2 and raises in_ready in that same cycle.
- Simultaneous events: S2 unload, S1-to-S2 move and a new S1 load can all happen on the same edge without loss or duplication.
- Reset mid-transfer: all in-flight results are discarded and are not counted in err_count.

## Test plan
- Reset: assert resetn=0 mid-stream with both stages full -> out_valid=0, err_count=0 immediately; in_ready=1 after release.
- Full legal sweep: tens 0x7F with ones 0x40..0x18, then tens 0x79 with each ones, out_ready=1 -> values 0..19 in order, each 2 cycles after accept; out_range=1 only for 16..19; one result per cycle.
- Illegal patterns: (0x7F, 0x7F), (0x40, 0x40), (0x79, 0x01) -> out_err=1, out_value=0 for each; err_count = 3 after their transfers.
- Backpressure: out_ready=0 while sending 5, 12, 7 -> 5 and 12 accepted, in_ready=0 holds 7. Raise out_ready -> outputs 5, 12, 7 in order with no loss or duplication; out_value stable while stalled.
- Saturation and clear: ERR_W=2, send 5 errored pairs -> err_count stays at 3. Pulse clear_err on the same cycle as an errored output transfer -> err_count=0.
- Random valid/ready toggling over 1000 pairs -> output sequence matches a reference decode with no drops or duplicates.
